// File: rtl/operand_fwd_stage_pkg.sv
// Shared constants for the operand forwarding stage.
// Select codes for the per-channel forwarding mux.
package operand_fwd_stage_pkg;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MWB = 2'b10;
endpackage

// File: rtl/operand_fwd_stage_fwd_sel.sv
// One operand channel: address compare, priority select,
// load-use hit and 3:1 data mux (purely combinational).
module fwd_sel
  import operand_fwd_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [WIDTH-1:0]  rf_data,
  input  logic              exm_wr,
  input  logic [ADDR_W-1:0] exm_addr,
  input  logic [WIDTH-1:0]  exm_data,
  input  logic              mwb_wr,
  input  logic [ADDR_W-1:0] mwb_addr,
  input  logic [WIDTH-1:0]  mwb_data,
  input  logic              ex_load,
  input  logic [ADDR_W-1:0] ex_addr,
  output logic [SEL_W-1:0]  sel,
  output logic [WIDTH-1:0]  data,
  output logic              hit
);
  logic nz;
  logic exm_hit;
  logic mwb_hit;

  // register 0 is hard-wired, never forwarded or stalled on
  assign nz      = |src;
  assign exm_hit = exm_wr & nz & (exm_addr == src);
  assign mwb_hit = mwb_wr & nz & (mwb_addr == src);
  assign hit     = ex_load & nz & (ex_addr == src);

  always_comb begin
    sel = SEL_RF;
    unique case (1'b1)
      exm_hit:            sel = SEL_EXM;
      mwb_hit & ~exm_hit: sel = SEL_MWB;
      default:            sel = SEL_RF;
    endcase
  end

  always_comb begin
    data = rf_data;
    case (sel)
      SEL_EXM: data = exm_data;
      SEL_MWB: data = mwb_data;
      default: data = rf_data;
    endcase
  end
endmodule

// File: rtl/operand_fwd_stage.sv
// ID-stage operand forwarding for CH channels with load-use
// stall detection and a registered ID/EX operand bundle.
module operand_fwd_stage
  import operand_fwd_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CH     = 2,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [CH*ADDR_W-1:0]  src_addr_i,
  input  logic [CH*WIDTH-1:0]   rf_data_i,
  input  logic                  exm_wr_i,
  input  logic [ADDR_W-1:0]     exm_addr_i,
  input  logic [WIDTH-1:0]      exm_data_i,
  input  logic                  mwb_wr_i,
  input  logic [ADDR_W-1:0]     mwb_addr_i,
  input  logic [WIDTH-1:0]      mwb_data_i,
  input  logic                  ex_load_i,
  input  logic [ADDR_W-1:0]     ex_addr_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [CH*WIDTH-1:0]   opnd_o,
  output logic [CH*SEL_W-1:0]   sel_o,
  output logic [CNT_W-1:0]      lu_cnt_o
);
  logic [CH*SEL_W-1:0] sel;
  logic [CH*WIDTH-1:0] mux;
  logic [CH-1:0]       hit;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    fwd_sel #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_sel (
      .src      (src_addr_i[k*ADDR_W +: ADDR_W]),
      .rf_data  (rf_data_i[k*WIDTH +: WIDTH]),
      .exm_wr   (exm_wr_i),
      .exm_addr (exm_addr_i),
      .exm_data (exm_data_i),
      .mwb_wr   (mwb_wr_i),
      .mwb_addr (mwb_addr_i),
      .mwb_data (mwb_data_i),
      .ex_load  (ex_load_i),
      .ex_addr  (ex_addr_i),
      .sel      (sel[k*SEL_W +: SEL_W]),
      .data     (mux[k*WIDTH +: WIDTH]),
      .hit      (hit[k])
    );
  end

  assign stall_o = valid_i & (|hit) & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      opnd_o   <= '0;
      sel_o    <= '0;
      lu_cnt_o <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      opnd_o  <= '0;
      sel_o   <= '0;
    end else if (stall_i) begin
      valid_o <= valid_o;
    end else if (stall_o) begin
      // bubble into EX; the held instruction re-issues next cycle
      valid_o <= 1'b0;
      opnd_o  <= '0;
      sel_o   <= '0;
      if (~&lu_cnt_o) lu_cnt_o <= lu_cnt_o + CNT_W'(1);
    end else begin
      valid_o <= valid_i;
      opnd_o  <= mux;
      sel_o   <= sel;
    end
  end
endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed bench for operand_fwd_stage; a second instance
// with a 2-bit counter covers saturation.
module tb_operand_fwd_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [4:0]  src0, src1;
  logic [31:0] rf0, rf1;
  logic        exm_wr, mwb_wr, ex_load;
  logic [4:0]  exm_addr, mwb_addr, ex_addr;
  logic [31:0] exm_data, mwb_data;
  logic        stall, flush;

  logic        stall_o, valid_o, stall2, valid2;
  logic [63:0] opnd, opnd2;
  logic [3:0]  sel, sel2;
  logic [15:0] lu;
  logic [1:0]  lu2;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  operand_fwd_stage u_dut (
    .clk_i (clk), .rst_i (rst), .valid_i (valid),
    .src_addr_i ({src1, src0}), .rf_data_i ({rf1, rf0}),
    .exm_wr_i (exm_wr), .exm_addr_i (exm_addr),
    .exm_data_i (exm_data),
    .mwb_wr_i (mwb_wr), .mwb_addr_i (mwb_addr),
    .mwb_data_i (mwb_data),
    .ex_load_i (ex_load), .ex_addr_i (ex_addr),
    .stall_i (stall), .flush_i (flush),
    .stall_o (stall_o), .valid_o (valid_o),
    .opnd_o (opnd), .sel_o (sel), .lu_cnt_o (lu)
  );

  operand_fwd_stage #(.CNT_W(2)) u_sat (
    .clk_i (clk), .rst_i (rst), .valid_i (valid),
    .src_addr_i ({src1, src0}), .rf_data_i ({rf1, rf0}),
    .exm_wr_i (exm_wr), .exm_addr_i (exm_addr),
    .exm_data_i (exm_data),
    .mwb_wr_i (mwb_wr), .mwb_addr_i (mwb_addr),
    .mwb_data_i (mwb_data),
    .ex_load_i (ex_load), .ex_addr_i (ex_addr),
    .stall_i (stall), .flush_i (flush),
    .stall_o (stall2), .valid_o (valid2),
    .opnd_o (opnd2), .sel_o (sel2), .lu_cnt_o (lu2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0;
    src0 = '0; src1 = '0; rf0 = '0; rf1 = '0;
    exm_wr = 1'b0; exm_addr = '0; exm_data = '0;
    mwb_wr = 1'b0; mwb_addr = '0; mwb_data = '0;
    ex_load = 1'b0; ex_addr = '0;
    stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_opnd", opnd, 64'h0);
    chk("rst_sel", 64'(sel), 64'(0));
    chk("rst_cnt", 64'(lu), 64'(0));
    chk("rst_stall", 64'(stall_o), 64'(0));

    // double match: EX/MEM wins
    valid = 1'b1; src0 = 5'd5; rf0 = 32'h1111;
    src1 = 5'd3; rf1 = 32'h2222;
    exm_wr = 1'b1; exm_addr = 5'd5; exm_data = 32'hAAAA;
    mwb_wr = 1'b1; mwb_addr = 5'd5; mwb_data = 32'hBBBB;
    step();
    chk("prio_opnd", opnd, {32'h2222, 32'hAAAA});
    chk("prio_sel", 64'(sel), 64'(4'b0001));
    chk("prio_valid", 64'(valid_o), 64'(1));

    exm_wr = 1'b0;
    step();
    chk("mwb_opnd", opnd, {32'h2222, 32'hBBBB});
    chk("mwb_sel", 64'(sel), 64'(4'b0010));

    // register 0: no forwarding, no stall
    src0 = 5'd0; exm_addr = 5'd0; exm_wr = 1'b1;
    mwb_wr = 1'b0; ex_load = 1'b1; ex_addr = 5'd0;
    #1;
    chk("zero_stall", 64'(stall_o), 64'(0));
    step();
    chk("zero_opnd", opnd, {32'h2222, 32'h1111});
    chk("zero_sel", 64'(sel), 64'(0));

    // load-use on channel 1
    exm_wr = 1'b0; src1 = 5'd8; ex_addr = 5'd8;
    #1;
    chk("lu_stall", 64'(stall_o), 64'(1));
    step();
    chk("lu_valid", 64'(valid_o), 64'(0));
    chk("lu_opnd", opnd, 64'h0);
    chk("lu_cnt", 64'(lu), 64'(1));

    // re-issue: load result now in EX/MEM
    ex_load = 1'b0; exm_wr = 1'b1; exm_addr = 5'd8;
    exm_data = 32'hCCCC;
    #1;
    chk("reiss_stall", 64'(stall_o), 64'(0));
    step();
    chk("reiss_opnd", opnd, {32'hCCCC, 32'h1111});
    chk("reiss_sel", 64'(sel), 64'(4'b0100));
    chk("reiss_valid", 64'(valid_o), 64'(1));

    // downstream hold with changing inputs
    stall = 1'b1; rf0 = 32'h9999;
    step();
    chk("hold1_opnd", opnd, {32'hCCCC, 32'h1111});
    exm_data = 32'hDDDD;
    step();
    chk("hold2_opnd", opnd, {32'hCCCC, 32'h1111});
    ex_load = 1'b1;
    #1;
    chk("hold3_stall", 64'(stall_o), 64'(1));
    step();
    chk("hold3_opnd", opnd, {32'hCCCC, 32'h1111});
    chk("hold3_sel", 64'(sel), 64'(4'b0100));
    chk("hold3_valid", 64'(valid_o), 64'(1));
    chk("hold3_cnt", 64'(lu), 64'(1));

    // flush beats stall and load-use
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(stall_o), 64'(0));
    step();
    chk("flush_valid", 64'(valid_o), 64'(0));
    chk("flush_opnd", opnd, 64'h0);
    chk("flush_sel", 64'(sel), 64'(0));
    chk("flush_cnt", 64'(lu), 64'(1));

    flush = 1'b0; stall = 1'b0; ex_load = 1'b0;
    step();
    chk("pre_rst_opnd", opnd, {32'hDDDD, 32'h9999});

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_o), 64'(0));
    chk("arst_opnd", opnd, 64'h0);
    chk("arst_sel", 64'(sel), 64'(0));
    chk("arst_cnt", 64'(lu), 64'(0));
    rst = 1'b0;
    step();
    chk("post_rst_opnd", opnd, {32'hDDDD, 32'h9999});
    chk("post_rst_valid", 64'(valid_o), 64'(1));

    // five bubbles: 16-bit counts 5, 2-bit saturates at 3
    ex_load = 1'b1;
    repeat (5) step();
    chk("sat_cnt16", 64'(lu), 64'(5));
    chk("sat_cnt2", 64'(lu2), 64'(3));
    chk("sat_valid", 64'(valid_o), 64'(0));

    // valid_i low: no stall, muxed data still loaded
    valid = 1'b0;
    #1;
    chk("inv_stall", 64'(stall_o), 64'(0));
    step();
    chk("inv_valid", 64'(valid_o), 64'(0));
    chk("inv_opnd", opnd, {32'hDDDD, 32'h9999});
    chk("inv_sel", 64'(sel), 64'(4'b0100));
    chk("inv_cnt", 64'(lu), 64'(5));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
